// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC redirect sequencer.
// State encoding, redirect source codes, PC step and the default reset PC.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JAL  = 2'd1,
        SRC_JALR = 2'd2,
        SRC_BR   = 2'd3
    } src_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pc_seq_pkg

// File: rtl/redirect_arbiter.sv
// Combinational priority select of redirect targets: branch > JALR > JAL.
// The JALR target always has bit0 cleared. Without PC_MISALIGN_TRAP_EN the
// selected target is also forced word aligned. With the macro defined, bits
// [1:0] pass through so the sequencer can trap on them.
module redirect_arbiter
    import pc_seq_pkg::*;
(
    input  logic        jal_valid_i,
    input  logic [31:0] jal_target_i,
    input  logic        jalr_valid_i,
    input  logic [31:0] jalr_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        redirect_valid,
    output src_e        redirect_src,
    output logic [31:0] redirect_target
);

    logic [31:0] raw_target_s;

    // Pick the oldest redirecting instruction; a same-cycle JAL is on the wrong path.
    always_comb begin
        redirect_valid = 1'b0;
        redirect_src   = SRC_NONE;
        raw_target_s   = 32'h0000_0000;
        if (br_taken_i) begin
            redirect_valid = 1'b1;
            redirect_src   = SRC_BR;
            raw_target_s   = br_target_i;
        end else if (jalr_valid_i) begin
            redirect_valid = 1'b1;
            redirect_src   = SRC_JALR;
            raw_target_s   = jalr_target_i & 32'hFFFF_FFFE;
        end else if (jal_valid_i) begin
            redirect_valid = 1'b1;
            redirect_src   = SRC_JAL;
            raw_target_s   = jal_target_i;
        end else begin
            redirect_valid = 1'b0;
            redirect_src   = SRC_NONE;
            raw_target_s   = 32'h0000_0000;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign redirect_target = raw_target_s;
`else
    assign redirect_target = raw_target_s & 32'hFFFF_FFFC;
`endif

endmodule : redirect_arbiter

// File: rtl/pc_redirect_sequencer.sv
// PC redirect sequencer: owns the fetch PC, arbitrates redirects, inserts a
// one-cycle flush bubble, and handles stall and sticky halt.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap on misaligned targets,
// adds the misalign_o port).
module pc_redirect_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 jal_valid_i,
    input  logic [31:0]          jal_target_i,
    input  logic                 jalr_valid_i,
    input  logic [31:0]          jalr_target_i,
    input  logic                 br_taken_i,
    input  logic [31:0]          br_target_i,
    output logic [31:0]          pc_o,
    output logic [31:0]          pc_plus4_o,
    output logic                 fetch_valid_o,
    output logic                 flush_o,
    output logic                 halted_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                 misalign_o,
`endif
    output logic [CNT_WIDTH-1:0] redirect_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_r, next_state_s;
    logic [31:0]          pc_r, pc_next_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
    logic                 fetch_valid_r, flush_r, halted_r;
    logic                 misalign_r, misalign_next_s;

    logic                 redirect_valid_s;
    src_e                 redirect_src_s;
    logic [31:0]          redirect_target_s;
    logic                 redirect_take_s;

    redirect_arbiter u_arbiter (
        .jal_valid_i     (jal_valid_i),
        .jal_target_i    (jal_target_i),
        .jalr_valid_i    (jalr_valid_i),
        .jalr_target_i   (jalr_target_i),
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .redirect_valid  (redirect_valid_s),
        .redirect_src    (redirect_src_s),
        .redirect_target (redirect_target_s)
    );

    // A redirect is taken only when the valid flag and source code agree.
    assign redirect_take_s = redirect_valid_s && (redirect_src_s != SRC_NONE);

    // Next-state, next-PC, counter and trap-flag decode.
    always_comb begin
        next_state_s    = state_r;
        pc_next_s       = pc_r;
        cnt_next_s      = cnt_r;
        misalign_next_s = misalign_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_take_s) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (redirect_target_s[1:0] != 2'b00) begin
                        next_state_s    = ST_HALT;
                        misalign_next_s = 1'b1;
                    end else begin
                        next_state_s = ST_FLUSH;
                        pc_next_s    = redirect_target_s;
                        cnt_next_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                    end
`else
                    next_state_s = ST_FLUSH;
                    pc_next_s    = redirect_target_s;
                    cnt_next_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
`endif
                end else if (halt_i) begin
                    next_state_s = ST_HALT;
                end else if (stall_i) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s = pc_r + PC_STEP;
                end
            end
            ST_FLUSH: begin
                next_state_s = ST_RUN;
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_HALT;
            end
        endcase
    end

    // State, PC, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            cnt_r         <= {CNT_WIDTH{1'b0}};
            misalign_r    <= 1'b0;
            fetch_valid_r <= 1'b1;
            flush_r       <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= pc_next_s;
            cnt_r         <= cnt_next_s;
            misalign_r    <= misalign_next_s;
            fetch_valid_r <= (next_state_s == ST_RUN);
            flush_r       <= (next_state_s == ST_FLUSH);
            halted_r      <= (next_state_s == ST_HALT);
        end
    end

    assign pc_o           = pc_r;
    assign pc_plus4_o     = pc_r + PC_STEP;
    assign fetch_valid_o  = fetch_valid_r;
    assign flush_o        = flush_r;
    assign halted_o       = halted_r;
    assign redirect_cnt_o = cnt_r;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o     = misalign_r;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_r;
`endif

endmodule : pc_redirect_sequencer

// File: tb/tb_pc_redirect_sequencer.sv
// Directed testbench for pc_redirect_sequencer.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_pc_redirect_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, halt_i;
    logic        jal_valid_i, jalr_valid_i, br_taken_i;
    logic [31:0] jal_target_i, jalr_target_i, br_target_i;
    logic [31:0] pc_o, pc_plus4_o;
    logic        fetch_valid_o, flush_o, halted_o;
    logic [15:0] redirect_cnt_o;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_redirect_sequencer #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .halt_i         (halt_i),
        .jal_valid_i    (jal_valid_i),
        .jal_target_i   (jal_target_i),
        .jalr_valid_i   (jalr_valid_i),
        .jalr_target_i  (jalr_target_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .fetch_valid_o  (fetch_valid_o),
        .flush_o        (flush_o),
        .halted_o       (halted_o),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_o     (misalign_o),
`endif
        .redirect_cnt_o (redirect_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks PC, fetch_valid, flush, halted and counter in one call.
    task automatic chk_all(input string tag, input logic [31:0] pc, input logic fv,
                           input logic fl, input logic hl, input logic [15:0] cnt);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid_o}, {31'd0, fv});
        chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
        chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, hl});
        chk({tag, ".cnt"}, {16'd0, redirect_cnt_o}, {16'd0, cnt});
    endtask

    task automatic clear_redirects();
        jal_valid_i  = 1'b0;
        jalr_valid_i = 1'b0;
        br_taken_i   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; halt_i = 1'b0;
        jal_valid_i = 1'b0; jalr_valid_i = 1'b0; br_taken_i = 1'b0;
        jal_target_i = 32'h0; jalr_target_i = 32'h0; br_target_i = 32'h0;

        // Reset state and free run.
        step();
        rst = 1'b0;
        chk_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("reset.pc_plus4", pc_plus4_o, 32'h4);
`ifdef PC_MISALIGN_TRAP_EN
        chk("reset.misalign", {31'd0, misalign_o}, 32'd0);
`endif
        step(); chk_all("run1", 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);
        step(); chk_all("run2", 32'h8, 1'b1, 1'b0, 1'b0, 16'd0);
        step(); chk_all("run3", 32'hC, 1'b1, 1'b0, 1'b0, 16'd0);
        step(); chk("run4.pc", pc_o, 32'h10);

        // JAL at 0x10 to 0x40: bubble, then target fetched, then sequential.
        jal_valid_i = 1'b1; jal_target_i = 32'h40;
        step(); clear_redirects();
        chk_all("jal.flush", 32'h40, 1'b0, 1'b1, 1'b0, 16'd1);
        step(); chk_all("jal.fetch", 32'h40, 1'b1, 1'b0, 1'b0, 16'd1);
        step(); chk_all("jal.seq", 32'h44, 1'b1, 1'b0, 1'b0, 16'd1);

        // All three sources at once: branch wins, counter +1; held through FLUSH, ignored.
        br_taken_i = 1'b1; br_target_i = 32'h100;
        jalr_valid_i = 1'b1; jalr_target_i = 32'h201;
        jal_valid_i = 1'b1; jal_target_i = 32'h300;
        step(); chk_all("prio.flush", 32'h100, 1'b0, 1'b1, 1'b0, 16'd2);
        step(); clear_redirects();
        chk_all("prio.ignored", 32'h100, 1'b1, 1'b0, 1'b0, 16'd2);
        step(); chk_all("prio.seq", 32'h104, 1'b1, 1'b0, 1'b0, 16'd2);

        // JALR beats JAL when no branch.
        jalr_valid_i = 1'b1; jalr_target_i = 32'h61;
        jal_valid_i = 1'b1; jal_target_i = 32'h300;
        step(); clear_redirects();
        chk_all("jalr_over_jal", 32'h60, 1'b0, 1'b1, 1'b0, 16'd3);
        step();

        // Get to 0x20, then stall three cycles.
        jal_valid_i = 1'b1; jal_target_i = 32'h20;
        step(); clear_redirects();
        step(); chk_all("stall.pre", 32'h20, 1'b1, 1'b0, 1'b0, 16'd4);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall.hold.pc", pc_o, 32'h20);
        end
        chk("stall.fetch_valid", {31'd0, fetch_valid_o}, 32'd1);

        // JALR to 0x81 under stall: redirect overrides stall, bit0 cleared.
        jalr_valid_i = 1'b1; jalr_target_i = 32'h81;
        step(); clear_redirects(); stall_i = 1'b0;
        chk_all("stall.jalr", 32'h80, 1'b0, 1'b1, 1'b0, 16'd5);
        step(); chk_all("stall.jalr.fetch", 32'h80, 1'b1, 1'b0, 1'b0, 16'd5);
        step(); chk("stall.jalr.seq", pc_o, 32'h84);

        // Branch to 0x8; halt raised during FLUSH is ignored, then taken in RUN.
        br_taken_i = 1'b1; br_target_i = 32'h8;
        step(); clear_redirects(); halt_i = 1'b1;
        chk_all("halt.flush", 32'h8, 1'b0, 1'b1, 1'b0, 16'd6);
        step(); chk_all("halt.ignored_in_flush", 32'h8, 1'b1, 1'b0, 1'b0, 16'd6);
        step(); chk_all("halt.enter", 32'h8, 1'b0, 1'b0, 1'b1, 16'd6);

        // HALT is sticky: halt dropped and redirects offered, pc stays frozen.
        halt_i = 1'b0; jal_valid_i = 1'b1; jal_target_i = 32'h40;
        br_taken_i = 1'b1; br_target_i = 32'h200;
        for (int i = 0; i < 10; i++) begin
            step(); chk_all("halt.frozen", 32'h8, 1'b0, 1'b0, 1'b1, 16'd6);
        end

        // Reset overrides pending redirects and leaves HALT.
        rst = 1'b1;
        step(); rst = 1'b0; clear_redirects();
        chk_all("halt.reset", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);

        // PC wrap at the top of the address space.
        br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
        step(); clear_redirects();
        step(); chk("wrap.top.pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap.pc_plus4", pc_plus4_o, 32'h0);
        step(); chk_all("wrap.zero", 32'h0, 1'b1, 1'b0, 1'b0, 16'd1);

        // Misaligned branch target 0x42.
        br_taken_i = 1'b1; br_target_i = 32'h42;
        step(); clear_redirects();
`ifdef PC_MISALIGN_TRAP_EN
        chk_all("misalign.trap", 32'h0, 1'b0, 1'b0, 1'b1, 16'd1);
        chk("misalign.flag", {31'd0, misalign_o}, 32'd1);
        step(); chk("misalign.sticky", {31'd0, misalign_o}, 32'd1);
        chk("misalign.frozen.pc", pc_o, 32'h0);
`else
        chk_all("misalign.flush", 32'h40, 1'b0, 1'b1, 1'b0, 16'd2);
        step(); chk_all("misalign.fetch", 32'h40, 1'b1, 1'b0, 1'b0, 16'd2);
        step(); chk("misalign.seq", pc_o, 32'h44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_redirect_sequencer

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
- Owns the architectural PC register and is the consumer end of the jump-target path.
- Accepts redirect targets from the JAL destination calculator (ID stage), JALR and taken-branch resolution (EX stage).
- Arbitrates the targets, updates the PC, issues a one-cycle flush bubble, and sequences fetch through stall and halt.
- Sits between the hazard unit and instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; hold PC.
- halt_i  in  1  halt request (ecall-halt decode); sticky.
- jal_valid_i  in  1  JAL target valid (ID stage).
- jal_target_i  in  32  cur_pc + sext(imm_J)<<1.
- jalr_valid_i  in  1  JALR target valid (EX stage).
- jalr_target_i  in  32  rs1 + imm_I, unmasked.
- br_taken_i  in  1  branch resolved taken (EX stage).
- br_target_i  in  32  branch destination.
- pc_o  out  32  current fetch PC.
- pc_plus4_o  out  32  pc_o + 4, also used as link value.
- fetch_valid_o  out  1  pc_o is a real fetch this cycle.
- flush_o  out  1  kill IF/ID contents this cycle.
- halted_o  out  1  sequencer in HALT.
- misalign_o  out  1  misaligned target trapped; only exists with the optional feature.
- redirect_cnt_o  out  CNT_WIDTH  number of accepted redirects, saturating.

Behaviour:
- Reset (rst=1 at posedge):
  - pc_o=RESET_PC, state=RUN.
  - flush_o=0, halted_o=0, misalign_o=0, redirect_cnt_o=0.
  - fetch_valid_o=1 from the first cycle after reset.
  - rst overrides every other input, in any state.
- States: RUN, FLUSH, HALT.
- Redirect arbitration (combinational): br_taken_i > jalr_valid_i > jal_valid_i.
  - The older EX instruction wins; a same-cycle JAL from ID is dropped, because it is on the wrong path.
- JALR target has bit0 cleared before use. Other sources are used as given.
- RUN:
  - Redirect present: pc<=target, state<=FLUSH, redirect_cnt+=1 (saturates at all-ones). This holds even if stall_i=1; redirect overrides stall.
  - Else if halt_i: state<=HALT, pc held.
  - Else if stall_i: pc held.
  - Else: pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Outputs: fetch_valid_o=1, flush_o=0.
- FLUSH (exactly one cycle):
  - Outputs: flush_o=1, fetch_valid_o=0, pc_o=redirect target.
  - Redirect inputs are ignored, because they come from flushed instructions.
  - Next state is RUN; pc is not incremented on this edge.
  - The target is fetched in the first RUN cycle.
  - halt_i in FLUSH is ignored.
- HALT:
  - halted_o=1, fetch_valid_o=0, flush_o=0, pc frozen.
  - Only rst leaves HALT.
- Latency: redirect sampled at edge t. Flush bubble in cycle t+1, target fetched in cycle t+2.
- pc_plus4_o = pc_o + 4, combinational, always valid.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A winning target with target[1:0]!=00 (after the JALR bit0 clear) is not loaded.
  - Instead: state<=HALT, misalign_o<=1 (sticky until rst), redirect_cnt unchanged.
- Undefined:
  - target[1:0] is forced to 00 and the redirect proceeds normally.
  - misalign_o port is absent.

Decomposition:
- Package pc_seq_pkg holds:
  - state encoding: RUN=2'd0, FLUSH=2'd1, HALT=2'd2.
  - source codes: SRC_NONE, SRC_JAL, SRC_JALR, SRC_BR.
  - PC_STEP=32'd4.
  - default RESET_PC.
- Sub-module redirect_arbiter:
  - Purely combinational priority select.
  - Outputs: redirect_valid, redirect_src, masked target.
- The top level holds the FSM, PC register and counter.

Test Plan:
- Reset, then 3 free-run cycles -> pc_o = 0, 4, 8, C; fetch_valid_o=1; flush_o=0.
- At pc=0x10, jal_valid_i=1 with target 0x40 -> next cycle flush_o=1, fetch_valid_o=0, pc_o=0x40; following cycle pc_o=0x40, fetch_valid_o=1; then 0x44; redirect_cnt_o=1.
- Same cycle: br_taken_i (0x100), jalr_valid_i (0x201) and jal_valid_i (0x300) -> pc_o=0x100 after the edge; redirect_cnt_o +1 only.
- stall_i=1 for 3 cycles at pc=0x20 -> pc_o holds 0x20; a jalr to 0x81 during the stall -> pc=0x80 and a FLUSH cycle.
- halt_i at pc=0x8 -> halted_o=1, pc frozen for 10 cycles; rst -> pc_o=RESET_PC, halted_o=0.
- With PC_MISALIGN_TRAP_EN, br target 0x42 -> halted_o=1, misalign_o=1, pc unchanged. Without the macro -> pc_o=0x40 after the FLUSH cycle.
